// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises {cmd[1:0], payload} frames and serialises RAM read data on MISO.
// Optional read timeout enabled by defining SPI_TX_TIMEOUT_EN.
module spi_slave_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_timeout,
    output logic              busy
);
    localparam int unsigned RX_W  = DATA_W + 2;
    localparam int unsigned CNT_W = $clog2(RX_W + 1);

    typedef enum logic [2:0] {
        StIdle, StChkCmd, StWrite, StReadAdd, StReadData, StWaitTx, StSend, StHold
    } state_e;

    state_e            cs_q, cs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RX_W-2:0]   shift_q, shift_d;
    logic [RX_W-1:0]   rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              addr_rcvd_q, addr_rcvd_d;

`ifdef SPI_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TX_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            tx_timeout_q, tx_timeout_d;
`endif

    always_comb begin
        cs_d        = cs_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        miso_d      = miso_q;
        tx_shift_d  = tx_shift_q;
        addr_rcvd_d = addr_rcvd_q;
`ifdef SPI_TX_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        tx_timeout_d = 1'b0;
`endif
        if (SS_n) begin
            cs_d   = StIdle;
            cnt_d  = '0;
            miso_d = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            to_cnt_d = '0;
`endif
        end else begin
            unique case (cs_q)
                StIdle: begin
                    cs_d   = StChkCmd;
                    miso_d = 1'b0;
                end
                StChkCmd: begin
                    cnt_d = CNT_W'(RX_W);
                    if (!MOSI)            cs_d = StWrite;
                    else if (addr_rcvd_q) cs_d = StReadData;
                    else                  cs_d = StReadAdd;
                end
                StWrite, StReadAdd, StReadData: begin
                    shift_d = {shift_q[RX_W-3:0], MOSI};
                    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                    if (cnt_q <= CNT_W'(1)) begin
                        rx_data_d  = {shift_q, MOSI};
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        if (cs_q == StReadData) begin
                            cs_d = StWaitTx;
`ifdef SPI_TX_TIMEOUT_EN
                            to_cnt_d = '0;
`endif
                        end else begin
                            cs_d = StHold;
                        end
                        if (cs_q == StReadAdd) addr_rcvd_d = 1'b1;
                    end
                end
                StWaitTx: begin
                    if (tx_valid) begin
                        miso_d     = tx_data[DATA_W-1];
                        tx_shift_d = tx_data;
                        cnt_d      = CNT_W'(DATA_W - 1);
                        cs_d       = StSend;
`ifdef SPI_TX_TIMEOUT_EN
                    end else if (to_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
                        // Master still clocks out a byte; all-ones marks it as invalid data.
                        tx_timeout_d = 1'b1;
                        miso_d       = 1'b1;
                        tx_shift_d   = {DATA_W{1'b1}};
                        cnt_d        = CNT_W'(DATA_W - 1);
                        to_cnt_d     = '0;
                        cs_d         = StSend;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
`endif
                    end
                end
                StSend: begin
                    if (cnt_q != '0) begin
                        miso_d     = tx_shift_q[DATA_W-2];
                        tx_shift_d = tx_shift_q << 1;
                        cnt_d      = cnt_q - 1'b1;
                    end else begin
                        miso_d      = 1'b0;
                        addr_rcvd_d = 1'b0;
                        cs_d        = StHold;
                    end
                end
                StHold: miso_d = 1'b0;
                default: cs_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            tx_shift_q  <= '0;
            addr_rcvd_q <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            tx_shift_q  <= tx_shift_d;
            addr_rcvd_q <= addr_rcvd_d;
        end
    end

`ifdef SPI_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q     <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end
    assign tx_timeout = tx_timeout_q;
`else
    assign tx_timeout = 1'b0;
`endif

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (cs_q != StIdle);

endmodule
